// File: rtl/vmul_booth_seq_pkg.sv
// Shared vmul definitions for the sequential radix-4 Booth multiplier:
// sequencer state encodings and the iteration-count helper.
package vmul_booth_seq_pkg;

  typedef enum logic [1:0] {
    VMUL_BOOTH_ST_IDLE = 2'd0,
    VMUL_BOOTH_ST_CALC = 2'd1,
    VMUL_BOOTH_ST_DONE = 2'd2
  } vmul_booth_st_e;

  // One extra iteration covers the sign/zero extension window above the MSB
  function automatic int vmul_booth_niter(input int wordlen);
    return wordlen / 2 + 1;
  endfunction

endpackage

// File: rtl/vmul_booth_seq_enc.sv
// Radix-4 Booth encoder cell: selects 0, +/-A or +/-2A from a 3-bit window.
// Negation is one's complement; the caller adds 'sign' to finish it.
module vmul_booth_seq_enc #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [2:0]   s,
  output logic [W:0]   result,
  output logic         sign
);

  logic         one;
  logic         two;
  logic         neg;
  logic [W:0]   mag;

  // Zero windows are encoded as -0 so 000 and 111 behave identically
  assign one    = s[1] ^ s[0];
  assign two    = (s == 3'b011) | (s == 3'b100);
  assign neg    = s[2] | (s == 3'b000);
  assign mag    = one ? {a[W-1], a} : (two ? {a, 1'b0} : '0);
  assign result = neg ? ~mag : mag;
  assign sign   = neg;

endmodule

// File: rtl/vmul_booth_seq.sv
// Iterative radix-4 Booth multiplier: one operand pair in, one 2*WORDLEN
// product out, consuming two multiplier bits per cycle through one encoder.
module vmul_booth_seq
  import vmul_booth_seq_pkg::*;
#(
  parameter int WORDLEN = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORDLEN-1:0]     in_a,
  input  logic [WORDLEN-1:0]     in_b,
  input  logic                   in_signed,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [2*WORDLEN-1:0]   out_result,
  output logic                   busy
);

  localparam int NITER = vmul_booth_niter(WORDLEN);
  localparam int CW    = $clog2(NITER + 1);
  localparam int PW    = 2 * WORDLEN;

  vmul_booth_st_e        state;
  vmul_booth_st_e        state_next;
  logic [WORDLEN:0]      a_ext;
  logic [WORDLEN+2:0]    b_sh;
  logic [PW-1:0]         acc;
  logic [CW-1:0]         cnt;
  logic                  accept;
  logic                  last_iter;
  logic [WORDLEN+1:0]    enc_result;
  logic                  enc_sign;
  logic [PW-1:0]         pp;

  vmul_booth_seq_enc #(
    .W(WORDLEN + 1)
  ) u_enc (
    .a      (a_ext),
    .s      (b_sh[2:0]),
    .result (enc_result),
    .sign   (enc_sign)
  );

  // The multiplier register shifts right each iteration, so the active
  // window always sits in the low three bits; cnt only sets the weight.
  assign pp = ({{(PW - WORDLEN - 2){enc_result[WORDLEN+1]}}, enc_result}
               + PW'(enc_sign)) << {cnt, 1'b0};

  assign last_iter  = (cnt == CW'(NITER - 1));
  assign out_valid  = (state == VMUL_BOOTH_ST_DONE);
  assign busy       = (state != VMUL_BOOTH_ST_IDLE);
  assign out_result = acc;

  always_comb begin
    in_ready   = 1'b0;
    accept     = 1'b0;
    state_next = state;
    if (!flush) begin
      in_ready = (state == VMUL_BOOTH_ST_IDLE) |
                 ((state == VMUL_BOOTH_ST_DONE) & out_ready);
    end
    accept = in_valid & in_ready;
    case (state)
      VMUL_BOOTH_ST_IDLE: if (accept) state_next = VMUL_BOOTH_ST_CALC;
      VMUL_BOOTH_ST_CALC: if (last_iter) state_next = VMUL_BOOTH_ST_DONE;
      VMUL_BOOTH_ST_DONE: begin
        if (accept) state_next = VMUL_BOOTH_ST_CALC;
        else if (out_ready) state_next = VMUL_BOOTH_ST_IDLE;
      end
      default: state_next = VMUL_BOOTH_ST_IDLE;
    endcase
    if (flush) state_next = VMUL_BOOTH_ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= VMUL_BOOTH_ST_IDLE;
    else        state <= state_next;
  end

  // Flush outranks both a new accept and the final accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_ext <= '0;
      b_sh  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else if (flush) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept) begin
      a_ext <= {in_signed & in_a[WORDLEN-1], in_a};
      b_sh  <= {{2{in_signed & in_b[WORDLEN-1]}}, in_b, 1'b0};
      acc   <= '0;
      cnt   <= '0;
    end else if (state == VMUL_BOOTH_ST_CALC) begin
      acc  <= acc + pp;
      cnt  <= cnt + 1'b1;
      b_sh <= b_sh >> 2;
    end
  end

endmodule

// File: tb/tb_vmul_booth_seq.sv
// Self-checking bench for vmul_booth_seq: directed literal cases plus random
// traffic compared every cycle against a latency/product reference model.
module tb_vmul_booth_seq;

  localparam int W     = 32;
  localparam int NITER = W / 2 + 1;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    in_a;
  logic [W-1:0]    in_b;
  logic            in_signed;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  out_result;
  logic            busy;

  int checks = 0;
  int errors = 0;

  int              m_left;
  logic            m_valid;
  logic [2*W-1:0]  m_result;

  vmul_booth_seq #(.WORDLEN(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_signed  (in_signed),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_product(input logic [W-1:0] a,
                                                 input logic [W-1:0] b,
                                                 input logic s);
    logic signed [2*W-1:0] sa;
    logic signed [2*W-1:0] sb;
    if (s) begin
      sa = {{W{a[W-1]}}, a};
      sb = {{W{b[W-1]}}, b};
      return sa * sb;
    end
    return {{W{1'b0}}, a} * {{W{1'b0}}, b};
  endfunction

  function automatic logic model_ready();
    logic m_busy;
    m_busy = (m_left != 0) || m_valid;
    return !flush && (!m_busy || (m_valid && out_ready));
  endfunction

  task automatic compare(input string name, input logic [2*W-1:0] act,
                         input logic [2*W-1:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a product is due NITER edges after acceptance
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left   <= 0;
      m_valid  <= 1'b0;
      m_result <= '0;
    end else if (flush) begin
      m_left  <= 0;
      m_valid <= 1'b0;
    end else if (in_valid && model_ready()) begin
      m_left   <= NITER;
      m_valid  <= 1'b0;
      m_result <= ref_product(in_a, in_b, in_signed);
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) m_valid <= 1'b1;
    end
  end

  always @(negedge clk) begin
    compare("out_valid", {{(2*W-1){1'b0}}, out_valid}, {{(2*W-1){1'b0}}, m_valid});
    compare("in_ready", {{(2*W-1){1'b0}}, in_ready}, {{(2*W-1){1'b0}}, model_ready()});
    compare("busy", {{(2*W-1){1'b0}}, busy},
            {{(2*W-1){1'b0}}, (m_left != 0) || m_valid});
    if (m_valid) compare("out_result", out_result, m_result);
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic s);
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_valid  = 1'b1;
    @(posedge clk);
    #2;
    in_valid  = 1'b0;
    in_a      = $urandom;
    in_b      = $urandom;
    in_signed = $urandom_range(0, 1);
  endtask

  task automatic checkOutput(input logic [2*W-1:0] exp, input string name);
    int   edges;
    logic found;
    edges = 0;
    found = 1'b0;
    while (edges < 40 && !found) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (out_valid) found = 1'b1;
    end
    if (!found) begin
      checks = checks + 1;
      errors = errors + 1;
      $display("[TB] FAIL %s_timeout: got no out_valid within %0d edges, expected %0d",
               name, edges, NITER);
    end else begin
      compare({name, "_latency"}, 64'(edges), 64'(NITER));
      compare({name, "_result"}, out_result, exp);
    end
    @(posedge clk);
    #2;
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return 1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_signed = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    #1;
    compare("reset_out_result", out_result, 64'h0);
    compare("reset_in_ready", {63'd0, in_ready}, 64'd1);
    compare("reset_busy", {63'd0, busy}, 64'd0);
    #11 rst_n = 1'b1;
    @(posedge clk);
    #2;

    applyStimulus(32'hFFFF_FFFD, 32'd7, 1'b1);
    checkOutput(64'hFFFF_FFFF_FFFF_FFEB, "signed_m3x7");
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    checkOutput(64'hFFFF_FFFE_0000_0001, "unsigned_max");
    applyStimulus(32'h8000_0000, 32'd2, 1'b0);
    checkOutput(64'h0000_0001_0000_0000, "unsigned_msb_x2");
    applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1);
    checkOutput(64'h4000_0000_0000_0000, "signed_min_sq");
    applyStimulus(32'h0, 32'h1234_5678, 1'b1);
    checkOutput(64'h0, "zero_x");

    $display("[TB] backpressure");
    out_ready = 1'b0;
    applyStimulus(32'h1234, 32'h10, 1'b0);
    checkOutput(64'h12340, "bp_first");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      compare("bp_hold_result", out_result, 64'h12340);
      compare("bp_hold_in_ready", {63'd0, in_ready}, 64'd0);
      compare("bp_hold_valid", {63'd0, out_valid}, 64'd1);
    end
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    applyStimulus(32'd5, 32'd6, 1'b1);
    checkOutput(64'd30, "bp_back_to_back");

    $display("[TB] flush");
    applyStimulus(32'h1234, 32'h5678, 1'b0);
    repeat (8) @(posedge clk);
    #2 flush = 1'b1;
    @(posedge clk);
    #2 flush = 1'b0;
    @(negedge clk);
    compare("flush_busy", {63'd0, busy}, 64'd0);
    compare("flush_in_ready", {63'd0, in_ready}, 64'd1);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    compare("flush_no_valid", 64'(seen), 64'd0);
    @(posedge clk);
    #2;
    applyStimulus(32'd3, 32'd4, 1'b0);
    checkOutput(64'd12, "after_flush");

    $display("[TB] async reset");
    applyStimulus(32'h1234, 32'h5678, 1'b1);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    compare("rst_out_valid", {63'd0, out_valid}, 64'd0);
    compare("rst_out_result", out_result, 64'h0);
    compare("rst_busy", {63'd0, busy}, 64'd0);
    compare("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    applyStimulus(32'hFFFF_FFFF, 32'd1, 1'b1);
    checkOutput(64'hFFFF_FFFF_FFFF_FFFF, "after_reset");

    $display("[TB] random traffic");
    for (int c = 0; c < 1500; c++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_a      = pick_operand();
      in_b      = pick_operand();
      in_signed = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      @(posedge clk);
      #2;
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (30) @(posedge clk);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
